// File: rtl/audio_pkg.sv
// Shared definitions for the audio packet scheduler: FSM encoding, packet context and byte formats.
// No logic of its own; imported by the scheduler and its round-robin selector.
package audio_pkg;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_SYNC = 3'd1,
      ST_ID   = 3'd2,
      ST_DATA = 3'd3,
      ST_CSUM = 3'd4
   } state_t;

   localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hA5;
   localparam logic [3:0] ID_UPPER_NIBBLE   = 4'h0;
   localparam int         MAX_SAMPLE_W      = 32;

   // Everything the byte datapath needs for the packet currently on the wire.
   typedef struct packed {
      logic [3:0]              ch;
      logic [1:0]              cnt;
      logic [7:0]              csum;
      logic [MAX_SAMPLE_W-1:0] shift;
   } pkt_t;

   function automatic logic [7:0] id_byte(input logic [3:0] ch);
      return {ID_UPPER_NIBBLE, ch};
   endfunction

endpackage

// File: rtl/rr_pick.sv
// Round-robin selector: first set bit of pend at or after ptr, wrapping modulo N.
// Latency: combinational. Backpressure: none, pure function of its inputs.
// Returns a one-hot grant, the binary index of that grant and a found flag.
module rr_pick #(
   parameter int N  = 2,
   parameter int IW = (N > 1) ? $clog2(N) : 1
) (
   input  logic [N-1:0]  pend,
   input  logic [IW-1:0] ptr,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] idx,
   output logic          found
);

   int c;

   // Scan from the farthest offset down so the nearest pending channel wins.
   always_comb begin
      grant = '0;
      idx   = '0;
      found = 1'b0;
      c     = 0;
      for (int off = N - 1; off >= 0; off--) begin
         c = (int'(ptr) + off) % N;
         if (pend[c]) begin
            grant    = '0;
            grant[c] = 1'b1;
            idx      = IW'(c);
            found    = 1'b1;
         end
      end
   end

endmodule

// File: rtl/audio_frame_sched.sv
// Shares one UART byte transmitter between N_CH sample sources as framed packets (sync, id, data LSB first, xor).
// Latency: SYNC offered two edges after capture when idle; one idle cycle separates back-to-back packets.
// Backpressure: stalls on i_tx_ready low holding data; each channel's single-entry buffer drops and flags overrun when full.
module audio_frame_sched
   import audio_pkg::*;
#(
   parameter int          N_CH      = 2,
   parameter int          SAMPLE_W  = 16,
   parameter logic [7:0]  SYNC_BYTE = SYNC_BYTE_DEFAULT
) (
   input  logic                     i_clk,
   input  logic                     i_rst,
   input  logic [N_CH*SAMPLE_W-1:0] i_sample,
   input  logic [N_CH-1:0]          i_sample_valid,
   output logic [N_CH-1:0]          o_sample_ready,
   output logic [N_CH-1:0]          o_overrun,
   output logic [7:0]               o_tx_data,
   output logic                     o_tx_valid,
   input  logic                     i_tx_ready,
   output logic                     o_busy
);

   localparam int         IW        = (N_CH > 1) ? $clog2(N_CH) : 1;
   localparam int         NB        = SAMPLE_W / 8;
   localparam logic [1:0] LAST_BYTE = 2'(NB - 1);

   state_t                  state;
   state_t                  state_nxt;
   pkt_t                    pkt;
   logic [SAMPLE_W-1:0]     smp_buf [N_CH];
   logic [N_CH-1:0]         empty_q;
   logic [N_CH-1:0]         ovr_q;
   logic [IW-1:0]           rr_ptr;
   logic [N_CH-1:0]         grant;
   logic [IW-1:0]           pick_idx;
   logic                    pick_found;
   logic                    arb;
   logic                    tx_fire;
   logic [MAX_SAMPLE_W-1:0] load_word;

   rr_pick #(.N(N_CH), .IW(IW)) u_rr_pick (
      .pend  (~empty_q),
      .ptr   (rr_ptr),
      .grant (grant),
      .idx   (pick_idx),
      .found (pick_found)
   );

   assign arb       = (state == ST_IDLE) && pick_found;
   assign tx_fire   = (state != ST_IDLE) && i_tx_ready;
   assign load_word = MAX_SAMPLE_W'(smp_buf[pick_idx]);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state <= ST_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         ST_IDLE: if (pick_found) state_nxt = ST_SYNC;
         ST_SYNC: if (tx_fire) state_nxt = ST_ID;
         ST_ID:   if (tx_fire) state_nxt = ST_DATA;
         ST_DATA: if (tx_fire && pkt.cnt == LAST_BYTE) state_nxt = ST_CSUM;
         ST_CSUM: if (tx_fire) state_nxt = ST_IDLE;
         default: state_nxt = ST_IDLE;
      endcase
   end

   // Outputs decode only registered state, so nothing combinational from the inputs reaches a port.
   always_comb begin
      o_tx_valid = 1'b0;
      o_tx_data  = 8'h00;
      o_busy     = (state != ST_IDLE);
      case (state)
         ST_SYNC: begin
            o_tx_valid = 1'b1;
            o_tx_data  = SYNC_BYTE;
         end
         ST_ID: begin
            o_tx_valid = 1'b1;
            o_tx_data  = id_byte(pkt.ch);
         end
         ST_DATA: begin
            o_tx_valid = 1'b1;
            o_tx_data  = pkt.shift[7:0];
         end
         ST_CSUM: begin
            o_tx_valid = 1'b1;
            o_tx_data  = pkt.csum;
         end
         default: ;
      endcase
   end

   assign o_sample_ready = empty_q;
   assign o_overrun      = ovr_q;

   // A granted buffer is never being written on the same edge: its ready was already low.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         empty_q <= '1;
         ovr_q   <= '0;
      end else begin
         for (int c = 0; c < N_CH; c++) begin
            if (arb && grant[c]) begin
               empty_q[c] <= 1'b1;
            end else if (i_sample_valid[c] && empty_q[c]) begin
               empty_q[c] <= 1'b0;
            end
            if (i_sample_valid[c] && !empty_q[c]) begin
               ovr_q[c] <= 1'b1;
            end
         end
      end
   end

   always_ff @(posedge i_clk) begin
      for (int c = 0; c < N_CH; c++) begin
         if (i_sample_valid[c] && empty_q[c]) begin
            smp_buf[c] <= i_sample[c*SAMPLE_W +: SAMPLE_W];
         end
      end
   end

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         pkt    <= '0;
         rr_ptr <= '0;
      end else if (arb) begin
         pkt.ch    <= 4'(pick_idx);
         pkt.cnt   <= '0;
         pkt.csum  <= '0;
         pkt.shift <= load_word;
         rr_ptr    <= (pick_idx == IW'(N_CH - 1)) ? '0 : pick_idx + 1'b1;
      end else if (tx_fire) begin
         case (state)
            ST_ID: begin
               pkt.csum <= pkt.csum ^ id_byte(pkt.ch);
            end
            ST_DATA: begin
               pkt.csum  <= pkt.csum ^ pkt.shift[7:0];
               pkt.shift <= pkt.shift >> 8;
               pkt.cnt   <= pkt.cnt + 2'd1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_audio_frame_sched.sv
// Bench for audio_frame_sched: byte-queue packet model compared every cycle plus directed literal checks.
module tb_audio_frame_sched;

   localparam int N_CH = 2;
   localparam int SW   = 16;
   localparam int NB   = SW / 8;

   logic                 i_clk = 1'b0;
   logic                 i_rst = 1'b1;
   logic [N_CH*SW-1:0]   i_sample = '0;
   logic [N_CH-1:0]      i_sample_valid = '0;
   logic                 i_tx_ready = 1'b1;
   logic [N_CH-1:0]      o_sample_ready;
   logic [N_CH-1:0]      o_overrun;
   logic [7:0]           o_tx_data;
   logic                 o_tx_valid;
   logic                 o_busy;

   audio_frame_sched #(.N_CH(N_CH), .SAMPLE_W(SW), .SYNC_BYTE(8'hA5)) dut (
      .i_clk          (i_clk),
      .i_rst          (i_rst),
      .i_sample       (i_sample),
      .i_sample_valid (i_sample_valid),
      .o_sample_ready (o_sample_ready),
      .o_overrun      (o_overrun),
      .o_tx_data      (o_tx_data),
      .o_tx_valid     (o_tx_valid),
      .i_tx_ready     (i_tx_ready),
      .o_busy         (o_busy)
   );

   always #5 i_clk = ~i_clk;

   int checks = 0;
   int errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Model: per-channel holding slots, rr pointer, and the byte queue of the packet on the wire.
   logic [SW-1:0] m_val  [N_CH];
   logic          m_full [N_CH];
   logic          m_ovr  [N_CH];
   int            m_ptr;
   logic [7:0]    m_q [$];
   logic          m_on = 1'b0;
   logic [7:0]    tx_log [$];

   always @(posedge i_clk) begin : model
      logic       full_pre [N_CH];
      logic [7:0] cs;
      int         c;
      if (i_rst) begin
         for (int k = 0; k < N_CH; k++) begin
            m_full[k] = 1'b0;
            m_ovr[k]  = 1'b0;
            m_val[k]  = '0;
         end
         m_ptr = 0;
         m_q.delete();
         m_on  = 1'b1;
      end else if (m_on) begin
         if (o_tx_valid && i_tx_ready) tx_log.push_back(o_tx_data);
         for (int k = 0; k < N_CH; k++) full_pre[k] = m_full[k];
         if (m_q.size() > 0) begin
            if (i_tx_ready) void'(m_q.pop_front());
         end else begin
            for (int off = 0; off < N_CH; off++) begin
               c = (m_ptr + off) % N_CH;
               if (full_pre[c] && m_q.size() == 0) begin
                  m_q.push_back(8'hA5);
                  m_q.push_back(8'(c));
                  cs = 8'(c);
                  for (int b = 0; b < NB; b++) begin
                     m_q.push_back(8'(m_val[c] >> (8 * b)));
                     cs = cs ^ 8'(m_val[c] >> (8 * b));
                  end
                  m_q.push_back(cs);
                  m_full[c] = 1'b0;
                  m_ptr = (c + 1) % N_CH;
               end
            end
         end
         for (int k = 0; k < N_CH; k++) begin
            if (i_sample_valid[k]) begin
               if (!full_pre[k]) begin
                  m_full[k] = 1'b1;
                  m_val[k]  = i_sample[k*SW +: SW];
               end else begin
                  m_ovr[k] = 1'b1;
               end
            end
         end
      end
   end

   always @(negedge i_clk) begin : compare
      logic [13:0] exp_vec;
      logic [N_CH-1:0] rdy, ovr;
      if (m_on) begin
         for (int k = 0; k < N_CH; k++) begin
            rdy[k] = ~m_full[k];
            ovr[k] = m_ovr[k];
         end
         exp_vec = {m_q.size() > 0, (m_q.size() > 0) ? m_q[0] : 8'h00, m_q.size() > 0, rdy, ovr};
         check("cycle {valid,data,busy,ready,ovr}",
               32'({o_tx_valid, o_tx_data, o_busy, o_sample_ready, o_overrun}), 32'(exp_vec));
      end
   end

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic strobe(input int c, input logic [SW-1:0] v);
      i_sample[c*SW +: SW] = v;
      i_sample_valid[c]    = 1'b1;
      tick();
      i_sample_valid[c]    = 1'b0;
   endtask

   task automatic wait_done(input string name);
      int n = 0;
      while ((o_busy || o_sample_ready != 2'b11) && n < 300) begin
         tick();
         n++;
      end
      check({name, " drain within budget"}, 32'(n < 300), 32'd1);
   endtask

   task automatic check_log(input string name, input int n, input logic [79:0] exp);
      check({name, " byte count"}, tx_log.size(), n);
      for (int i = 0; i < n && i < tx_log.size(); i++)
         check($sformatf("%s byte%0d", name, i), 32'(tx_log[i]), 32'(exp[8*(n-1-i) +: 8]));
   endtask

   task automatic check_reset_vals(input string name);
      check({name, " ready"}, 32'(o_sample_ready), 32'h3);
      check({name, " overrun"}, 32'(o_overrun), 32'h0);
      check({name, " tx_valid"}, 32'(o_tx_valid), 32'h0);
      check({name, " tx_data"}, 32'(o_tx_data), 32'h0);
      check({name, " busy"}, 32'(o_busy), 32'h0);
   endtask

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
      $fatal(1, "timeout");
   end

   initial begin : stim
      int n;
      logic [15:0] k;
      tick();
      tick();
      check_reset_vals("reset");
      i_rst = 1'b0;
      tick();

      // Both channels strobed together from rr_ptr 0.
      tx_log.delete();
      i_sample       = {16'h00FF, 16'h0001};
      i_sample_valid = 2'b11;
      tick();
      i_sample_valid = 2'b00;
      check("dual ready after capture", 32'(o_sample_ready), 32'h0);
      check("dual valid one edge after capture", 32'(o_tx_valid), 32'h0);
      tick();
      check("dual sync two edges after capture", 32'({o_tx_valid, o_tx_data}), 32'h1A5);
      wait_done("dual");
      check_log("dual", 10, 80'hA5_00_01_00_01_A5_01_FF_00_FE);
      check("dual rr_ptr end", 32'(dut.rr_ptr), 32'h0);

      // Single sample, UART always ready.
      tx_log.delete();
      strobe(0, 16'h1234);
      wait_done("single");
      check_log("single", 5, 80'hA5_00_34_12_26);
      check("single busy after csum", 32'(o_busy), 32'h0);

      // Seven-cycle stall on the first data byte.
      tx_log.delete();
      strobe(0, 16'h1234);
      n = 0;
      while (!(o_tx_valid && o_tx_data == 8'hA5) && n < 20) begin
         tick();
         n++;
      end
      check("stall sync seen", 32'(n < 20), 32'd1);
      tick();
      tick();
      i_tx_ready = 1'b0;
      for (int i = 0; i < 7; i++) begin
         tick();
         check($sformatf("stall hold %0d", i), 32'({o_tx_valid, o_tx_data}), 32'h134);
      end
      i_tx_ready = 1'b1;
      wait_done("stall");
      check_log("stall", 5, 80'hA5_00_34_12_26);

      // Overrun on ch1 while its buffer waits behind a stalled ch0 packet.
      tx_log.delete();
      i_tx_ready = 1'b0;
      strobe(0, 16'h1111);
      strobe(1, 16'hBEEF);
      strobe(1, 16'hC0DE);
      strobe(1, 16'hDEAD);
      check("overrun flags", 32'(o_overrun), 32'h2);
      i_tx_ready = 1'b1;
      wait_done("overrun");
      check_log("overrun", 10, 80'hA5_00_11_11_00_A5_01_EF_BE_50);
      check("overrun sticky", 32'(o_overrun), 32'h2);

      // Fairness with both channels refilled as soon as they free up.
      tx_log.delete();
      n = 0;
      while (tx_log.size() < 8 * (3 + NB) && n < 2000) begin
         k = 16'(n);
         i_sample       = {16'h2000 + k, 16'h1000 + k};
         i_sample_valid = o_sample_ready;
         tick();
         n++;
      end
      i_sample_valid = 2'b00;
      check("fair packets within budget", 32'(n < 2000), 32'd1);
      wait_done("fair");
      if (tx_log.size() >= 8 * (3 + NB)) begin
         for (int p = 0; p < 8; p++)
            check($sformatf("fair packet%0d id", p), 32'(tx_log[p*(3+NB)+1]), 32'(p % 2));
      end
      check("fair no overrun ch0", 32'(o_overrun[0]), 32'h0);

      // Reset in the middle of the DATA phase, then a clean packet.
      tx_log.delete();
      strobe(0, 16'hABCD);
      n = 0;
      while (!(o_tx_valid && o_tx_data == 8'hCD) && n < 20) begin
         tick();
         n++;
      end
      check("midrst data phase seen", 32'(n < 20), 32'd1);
      i_rst = 1'b1;
      tick();
      check_reset_vals("midrst");
      i_rst = 1'b0;
      tick();
      tx_log.delete();
      strobe(1, 16'h1357);
      wait_done("post reset");
      check_log("post reset", 5, 80'hA5_01_57_13_45);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
